target_display: RTL

Multi-target, parametrised VGA target renderer. It holds up to NUM_TARGETS square targets, each with its own position, active flag and blink flag. For every pixel of the 25 MHz VGA scan it reports which targets cover that pixel. It sits between the game logic that places targets and the VGA colour mux. Positions are double-buffered and committed only at frame start, so a move never tears mid-frame.

---
 rtl/target_display_if.sv | 29 ++
 rtl/target_display.sv | 89 ++++++++
 2 files changed

// File: rtl/target_display_if.sv
// Bundle between the game/scan side and the target renderer: scan position,
// shadow-register write port and per-pixel hit outputs.
interface target_display_if #(
  parameter int NUM_TARGETS = 4,
  parameter int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
);
  logic                   start;
  logic [9:0]             h_cnt;
  logic [9:0]             v_cnt;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;
  logic [9:0]             wr_x;
  logic [9:0]             wr_y;
  logic                   wr_active;
  logic                   wr_blink;
  logic [NUM_TARGETS-1:0] enable_vec;
  logic                   enable_any;
  logic [IDX_W-1:0]       enable_idx;
  logic                   pending;

  modport master (
    output start, h_cnt, v_cnt, wr_en, wr_idx, wr_x, wr_y, wr_active, wr_blink,
    input  enable_vec, enable_any, enable_idx, pending
  );
  modport slave (
    input  start, h_cnt, v_cnt, wr_en, wr_idx, wr_x, wr_y, wr_active, wr_blink,
    output enable_vec, enable_any, enable_idx, pending
  );
endinterface

// File: rtl/target_display.sv
// Multi-target square renderer: double-buffered positions committed at frame
// start, blink phase per frame count, two-stage registered per-pixel hit vector.
module target_display #(
  parameter int NUM_TARGETS  = 4,
  parameter int SIZE         = 40,
  parameter int BLINK_FRAMES = 30
) (
  input  logic            clk,
  input  logic            rst,
  target_display_if.slave bus
);
  localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       blink;
  } tgt_t;

  tgt_t [NUM_TARGETS-1:0] shadow, live;
  logic                   pending;
  logic [FC_W-1:0]        frame_cnt;
  logic                   phase;
  logic [NUM_TARGETS-1:0] hit, s1, vec_q;
  logic                   any_q;
  logic [IDX_W-1:0]       idx_n, idx_q;
  logic                   frame_start, wr_ok;

  assign frame_start = (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0);
  assign wr_ok       = bus.wr_en && (int'(bus.wr_idx) < NUM_TARGETS);

  // Compare in 11 bits so a target near the right/bottom edge clips instead of wrapping.
  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_tgt
    logic [10:0] h, v, x, y;
    assign h = {1'b0, bus.h_cnt};
    assign v = {1'b0, bus.v_cnt};
    assign x = {1'b0, live[i].x};
    assign y = {1'b0, live[i].y};
    assign hit[i] = (h > x) && (h < x + 11'(SIZE)) && (v > y) && (v < y + 11'(SIZE))
                    && live[i].active && !(live[i].blink && phase) && bus.start;
  end

  always_comb begin
    idx_n = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--)
      if (s1[i]) idx_n = IDX_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      live      <= '0;
      pending   <= 1'b0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      s1        <= '0;
      vec_q     <= '0;
      any_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (frame_start) begin
        live    <= shadow;
        pending <= 1'b0;
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      // A write on the commit edge lands after the copy, so it waits a frame.
      if (wr_ok) begin
        shadow[bus.wr_idx] <= {bus.wr_x, bus.wr_y, bus.wr_active, bus.wr_blink};
        pending            <= 1'b1;
      end
      s1    <= hit;
      vec_q <= s1;
      any_q <= |s1;
      idx_q <= idx_n;
    end
  end

  assign bus.enable_vec = vec_q;
  assign bus.enable_any = any_q;
  assign bus.enable_idx = idx_q;
  assign bus.pending    = pending;
endmodule
